// File: rtl/increment_arbiter.sv
// Round-robin arbiter sharing one 4-bit +1 unit among NREQ requesters.
// Ports: clk/rst, req_valid/req_data/req_ready in; rsp_* registered out; busy.
module increment_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [3:0]        rsp_sum,
  output logic              rsp_co,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           valid_q, valid_d;
  logic [3:0]     sum_q, sum_d;
  logic           co_q, co_d;
  logic [IDW-1:0] id_q, id_d;

  logic           en;
  logic           found;
  logic [IDW-1:0] g;
  logic [IDW:0]   idx;
  logic [NREQ-1:0] grant_oh;
  logic [3:0]     a;
  logic [3:0]     s;
  logic [4:0]     c;

  assign en = !valid_q || rsp_ready;

  // Search from ptr upward with wrap; first valid bit wins.
  always_comb begin
    found = 1'b0;
    g     = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr_q} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NREQ))
        idx = idx - (IDW+1)'(NREQ);
      if (!found && req_valid[idx[IDW-1:0]]) begin
        found = 1'b1;
        g     = idx[IDW-1:0];
      end
    end
  end

  assign grant_oh  = found ? (NREQ'(1) << g) : '0;
  assign req_ready = (en && !rst) ? grant_oh : '0;

  // Operand mux; zero when nothing is granted.
  always_comb begin
    a = '0;
    for (int i = 0; i < NREQ; i++)
      if (grant_oh[i])
        a = a | req_data[4*i +: 4];
  end

  // Half-adder chain: carry-in of 1 ripples through.
  always_comb begin
    c[0] = 1'b1;
    s    = '0;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ c[i];
      c[i+1] = a[i] & c[i];
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    valid_d = valid_q;
    sum_d   = sum_q;
    co_d    = co_q;
    id_d    = id_q;
    if (en) begin
      if (found) begin
        valid_d = 1'b1;
        sum_d   = s;
        co_d    = c[4];
        id_d    = g;
        ptr_d   = (g == IDW'(NREQ-1)) ? '0 : g + 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      id_q    <= '0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      id_q    <= id_d;
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_sum   = sum_q;
  assign rsp_co    = co_q;
  assign rsp_id    = id_q;
  assign busy      = valid_q;

endmodule

// File: tb/tb_increment_arbiter.sv
// Bench for increment_arbiter: scoreboard of expected results.
// Directed scenarios plus a negedge monitor with a reference model.
module tb_increment_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_sum;
  logic        rsp_co;
  logic [1:0]  rsp_id;
  logic        busy;

  increment_arbiter #(.NREQ(4), .IDW(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_co(rsp_co),
    .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] sum;
    logic       co;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state, updated at each falling edge.
  int      mptr;
  bit      mvalid;
  bit      men;
  bit      mfound;
  int      mg;
  int      mi;
  logic [3:0] mexp_rdy;
  logic [3:0] mop;
  logic [4:0] mwide;
  exp_t    me;

  always @(negedge clk) begin
    if (rst) begin
      mptr   = 0;
      mvalid = 0;
      q.delete();
      chk("rst_rdy", 32'(req_ready), 32'd0);
    end else begin
      men    = !mvalid || rsp_ready;
      mfound = 0;
      mg     = 0;
      for (int k = 0; k < 4; k++) begin
        mi = (mptr + k) % 4;
        if (!mfound && req_valid[mi]) begin
          mfound = 1;
          mg     = mi;
        end
      end
      mexp_rdy = (men && mfound) ? (4'b0001 << mg) : 4'b0000;
      chk("rdy", 32'(req_ready), 32'(mexp_rdy));
      chk("vld", 32'(rsp_valid), 32'(mvalid));
      chk("busy", 32'(busy), 32'(mvalid));
      if (mvalid) begin
        if (q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          me = q[0];
          chk("sb_sum", 32'(rsp_sum), 32'(me.sum));
          chk("sb_co", 32'(rsp_co), 32'(me.co));
          chk("sb_id", 32'(rsp_id), 32'(me.id));
          if (rsp_ready)
            void'(q.pop_front());
        end
      end
      if (men) begin
        if (mfound) begin
          mop   = req_data[mg*4 +: 4];
          mwide = {1'b0, mop} + 5'd1;
          me.id  = 2'(mg);
          me.sum = mwide[3:0];
          me.co  = mwide[4];
          q.push_back(me);
          mptr   = (mg + 1) % 4;
          mvalid = 1;
        end else begin
          mvalid = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag,
                            input logic [3:0] s,
                            input logic co,
                            input logic [1:0] id);
    chk({tag, "_v"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_s"}, 32'(rsp_sum), 32'(s));
    chk({tag, "_c"}, 32'(rsp_co), 32'(co));
    chk({tag, "_i"}, 32'(rsp_id), 32'(id));
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    step();
    step();
    chk("rst_v", 32'(rsp_valid), 32'd0);
    chk("rst_s", 32'(rsp_sum), 32'd0);
    chk("rst_c", 32'(rsp_co), 32'd0);
    chk("rst_i", 32'(rsp_id), 32'd0);
    rst = 1'b0;
    step();

    // single requester 2, operand 7
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    req_data  = 16'h0700;
    #1 chk("single_rdy", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    expect_out("single", 4'h8, 1'b0, 2'd2);

    // carry wrap on requester 0 (ptr=3 so search wraps)
    req_valid = 4'b0001;
    req_data  = 16'h000F;
    step();
    req_valid = '0;
    expect_out("wrap", 4'h0, 1'b1, 2'd0);

    // requester 3 alone to bring ptr back to 0
    req_valid = 4'b1000;
    req_data  = 16'h6000;
    step();
    expect_out("p3", 4'h7, 1'b0, 2'd3);

    // round robin, all requesting
    req_valid = 4'b1111;
    req_data  = 16'h4321;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_out("rr", 4'((i % 4) + 2), 1'b0, 2'(i % 4));
    end

    // load id1 with operand 4, then hold it under backpressure
    req_data = 16'h4341;
    step();
    expect_out("bp_load", 4'h5, 1'b0, 2'd1);
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_rdy", 32'(req_ready), 32'd0);
      step();
      expect_out("bp_hold", 4'h5, 1'b0, 2'd1);
    end
    rsp_ready = 1'b1;
    #1 chk("bp_rel", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    expect_out("bp_next", 4'h4, 1'b0, 2'd2);

    // sparse: get ptr to 1, then 1001
    req_valid = 4'b0001;
    req_data  = 16'h0009;
    step();
    expect_out("sp_pre", 4'hA, 1'b0, 2'd0);
    req_valid = 4'b1001;
    req_data  = 16'hA00B;
    #1 chk("sp_rdy", 32'(req_ready), 32'b1000);
    step();
    expect_out("sp_3", 4'hB, 1'b0, 2'd3);
    rsp_ready = 1'b0;
    req_valid = 4'b1101;
    req_data  = 16'hA50B;
    step();
    req_valid = 4'b1001;
    step();
    expect_out("sp_hold", 4'hB, 1'b0, 2'd3);
    rsp_ready = 1'b1;
    #1 chk("sp_rdy0", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    expect_out("sp_0", 4'hC, 1'b0, 2'd0);
    step();
    chk("idle_v", 32'(rsp_valid), 32'd0);

    // reset mid-cycle with a held result
    req_valid = 4'b0001;
    req_data  = 16'h0005;
    step();
    req_valid = '0;
    rsp_ready = 1'b0;
    expect_out("pre_rst", 4'h6, 1'b0, 2'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_v", 32'(rsp_valid), 32'd0);
    chk("arst_s", 32'(rsp_sum), 32'd0);
    chk("arst_c", 32'(rsp_co), 32'd0);
    chk("arst_i", 32'(rsp_id), 32'd0);
    step();
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_v", 32'(rsp_valid), 32'd0);
    end

    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
